// File: rtl/spi_pkg.sv
// Shared SPI constants and the receive FSM state type.
// The optional build macro SPI_SLAVE_RX_MSB_FIRST_EN is consumed in spi_slave_rx.sv.
package spi_pkg;

    localparam int unsigned SPI_DATA_W          = 12;
    localparam int unsigned SPI_LEAD_SKIP       = 1;
    localparam int unsigned SPI_HALF_PERIOD_CLK = 11;
    localparam int unsigned SPI_SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } spi_rx_state_t;

    // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
    function automatic int unsigned spi_cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the received-word valid/ready bus of spi_slave_rx.
interface spi_slave_rx_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
) ();

    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    // Receiver side: the SPI slave itself.
    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

    // Driving side: SPI master pins and the word consumer.
    modport master (
        output sclk,
        output cs,
        output mosi,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detect for one pin, plus an
// equally delayed data tap so a companion pin lines up with the edges.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        SIG_RST     = 1'b1,
    parameter logic        TAP_RST     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    input  logic tap_i,
    output logic rise_c,
    output logic fall_c,
    output logic tap_o
);

    logic [SYNC_STAGES-1:0] sig_sync_q;
    logic [SYNC_STAGES-1:0] tap_sync_q;
    logic                   sig_prev_q;

    // Synchronizer chains and the edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_sync_q <= {SYNC_STAGES{SIG_RST}};
            tap_sync_q <= {SYNC_STAGES{TAP_RST}};
            sig_prev_q <= SIG_RST;
        end else begin
            sig_sync_q <= {sig_sync_q[SYNC_STAGES-2:0], sig_i};
            tap_sync_q <= {tap_sync_q[SYNC_STAGES-2:0], tap_i};
            sig_prev_q <= sig_sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sig_sync_q[SYNC_STAGES-1] & ~sig_prev_q;
    assign fall_c = ~sig_sync_q[SYNC_STAGES-1] & sig_prev_q;
    assign tap_o  = tap_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive slave: oversamples cs/sclk/mosi in the clk domain, reassembles
// DATA_W-bit frames and presents them through a one-deep valid/ready register.
// Build option: define SPI_SLAVE_RX_MSB_FIRST_EN to shift MSB-first
// (default is LSB-first, matching the in-house master).
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned LEAD_SKIP   = SPI_LEAD_SKIP,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_rx_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned SKIP_W = spi_cnt_w(LEAD_SKIP);

    // Conditioned pin events
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;
    logic cs_tap;
    logic unused_sig;

    spi_rx_state_t     state_q,     state_d;
    logic [SKIP_W-1:0] skip_q,      skip_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic              pub_q,       pub_d;
    logic [DATA_W-1:0] rx_data_q,   rx_data_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q,   overrun_d;
    logic              busy_q,      busy_d;

    // sclk chain carries mosi as its tap so data is sampled at the sclk edge stage
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .SIG_RST     (1'b1),
        .TAP_RST     (1'b0)
    ) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.sclk),
        .tap_i  (bus.mosi),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall),
        .tap_o  (mosi_s)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .SIG_RST     (1'b1),
        .TAP_RST     (1'b1)
    ) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.cs),
        .tap_i  (1'b1),
        .rise_c (cs_rise),
        .fall_c (cs_fall),
        .tap_o  (cs_tap)
    );

    assign unused_sig = sclk_rise & cs_tap;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            skip_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pub_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pub_q       <= pub_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    // Frame FSM, shifter and holding-register next state
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pub_d       = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    skip_d    = SKIP_W'(LEAD_SKIP);
                    state_d   = (LEAD_SKIP == 0) ? SHIFT : LEAD;
                end
            end
            LEAD: begin
                // cs_rise outranks a coincident sclk edge
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end else if (sclk_fall) begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q == SKIP_W'(1)) begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end else if (sclk_fall) begin
`ifdef SPI_SLAVE_RX_MSB_FIRST_EN
                    shift_d = {shift_q[DATA_W-2:0], mosi_s};
`else
                    shift_d = {mosi_s, shift_q[DATA_W-1:1]};
`endif
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                // Trailing master bit is ignored; shift_q is kept for the publish cycle
                if (cs_rise) begin
                    state_d = IDLE;
                    pub_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Holding register: drain first, then a publish may refill in the same cycle
        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (pub_q) begin
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;

endmodule
